// File: rtl/key_scanner.sv
// Key synchroniser/debouncer with lowest-index encoder and FX0A wait-for-key handshake.
// Optional per-key debounce counters are built only when KEY_DEBOUNCE_EN is defined.
module key_scanner #(
  parameter int NUM_KEYS        = 16,
  parameter int CODE_W          = $clog2(NUM_KEYS),
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] inputs,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                key_pressed,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_multi,
  input  logic                wait_req,
  output logic                wait_valid,
  output logic [CODE_W-1:0]   wait_code,
  input  logic                wait_ack,
  output logic [1:0]          dbg_state
);

  if (NUM_KEYS < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("key_scanner: NUM_KEYS must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HOLD, ST_DONE} wait_state_e;

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  logic [NUM_KEYS-1:0] key_down_dly_q;
  logic [NUM_KEYS-1:0] rise;
  logic                pressed_q, multi_q;
  logic [CODE_W-1:0]   code_q, wait_code_q, wait_code_d;
  logic [CODE_W-1:0]   enc_code;
  logic                enc_any, enc_multi;
  wait_state_e         state_q, state_d;

  function automatic logic [CODE_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= inputs;
      s2_q <= s1_q;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_down_q;

  // Each key accepts a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_down_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (s2_q[i] == key_down_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          key_down_q[i] <= s2_q[i];
          cnt_q[i]      <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign key_down = key_down_q;
`else
  assign key_down = s2_q;
`endif

  assign rise = key_down & ~key_down_dly_q;

  always_comb begin
    enc_any   = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_down[i]) begin
        if (enc_any) enc_multi = 1'b1;
        enc_any = 1'b1;
      end
    end
    enc_code = lowest_idx(key_down);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_down_dly_q <= '0;
      pressed_q      <= 1'b0;
      code_q         <= '0;
      multi_q        <= 1'b0;
    end else begin
      key_down_dly_q <= key_down;
      pressed_q      <= enc_any;
      code_q         <= enc_code;
      multi_q        <= enc_multi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_code_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_code_q <= wait_code_d;
    end
  end

  // Only fresh presses (rise) count once armed, so keys held at arm time are ignored.
  always_comb begin
    state_d     = state_q;
    wait_code_d = wait_code_q;
    case (state_q)
      ST_IDLE:  if (wait_req) state_d = ST_ARMED;
      ST_ARMED: begin
        if (rise != '0) begin
          wait_code_d = lowest_idx(rise);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD:  if (!key_down[wait_code_q]) state_d = ST_DONE;
      ST_DONE:  if (wait_ack) state_d = wait_req ? ST_ARMED : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign key_pressed = pressed_q;
  assign key_code    = code_q;
  assign key_multi   = multi_q;
  assign wait_valid  = (state_q == ST_DONE);
  assign wait_code   = wait_code_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_key_scanner.sv
// Bench for key_scanner: directed test-plan scenarios plus random stimulus,
// all outputs checked every cycle against a history-based behavioural model.
module tb_key_scanner;
  localparam int NK  = 16;
  localparam int CW  = 4;
  localparam int DBC = 4;
`ifdef KEY_DEBOUNCE_EN
  localparam int DB = DBC;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = DB + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] inputs = '0;
  logic          wait_req = 1'b0, wait_ack = 1'b0;
  logic [NK-1:0] key_down;
  logic          key_pressed, key_multi, wait_valid;
  logic [CW-1:0] key_code, wait_code;
  logic [1:0]    dbg_state;

  key_scanner #(.NUM_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYCLES(DBC)) dut (
    .clk(clk), .rst(rst), .inputs(inputs), .key_down(key_down),
    .key_pressed(key_pressed), .key_code(key_code), .key_multi(key_multi),
    .wait_req(wait_req), .wait_valid(wait_valid), .wait_code(wait_code),
    .wait_ack(wait_ack), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [NK-1:0] m_s1, m_s2, m_kd, m_kdd;
  logic [NK-1:0] s2_hist[$];
  logic          m_pressed, m_multi;
  logic [CW-1:0] m_code, m_wcode;
  int            m_phase;  // 0 idle, 1 armed, 2 hold, 3 done
  bit            m_live = 1'b0;

  function automatic logic [CW-1:0] lowest(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return CW'(i);
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [NK-1:0] kd_old, rise_old, kd_new;
    bit all_diff;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_kd = '0; m_kdd = '0;
      s2_hist.delete();
      m_pressed = 0; m_multi = 0; m_code = '0; m_wcode = '0;
      m_phase = 0; m_live = 1'b1;
    end else begin
      kd_old   = m_kd;
      rise_old = m_kd & ~m_kdd;
      m_pressed = (kd_old != '0);
      m_code    = lowest(kd_old);
      m_multi   = ($countones(kd_old) >= 2);
      case (m_phase)
        0: if (wait_req) m_phase = 1;
        1: if (rise_old != '0) begin m_wcode = lowest(rise_old); m_phase = 2; end
        2: if (!kd_old[m_wcode]) m_phase = 3;
        default: if (wait_ack) m_phase = wait_req ? 1 : 0;
      endcase
      if (DB == 0) begin
        m_s2 = m_s1; m_s1 = inputs;
        m_kd = m_s2;
      end else begin
        // A key flips once its last DB synchronised samples all disagree with it.
        s2_hist.push_front(m_s2);
        if (s2_hist.size() > DB) void'(s2_hist.pop_back());
        kd_new = kd_old;
        if (s2_hist.size() == DB) begin
          for (int b = 0; b < NK; b++) begin
            all_diff = 1'b1;
            foreach (s2_hist[k]) if (s2_hist[k][b] == kd_old[b]) all_diff = 1'b0;
            if (all_diff) kd_new[b] = ~kd_old[b];
          end
        end
        m_s2 = m_s1; m_s1 = inputs;
        m_kd = kd_new;
      end
      m_kdd = kd_old;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("key_down",    32'(key_down),    32'(m_kd));
      check("key_pressed", 32'(key_pressed), 32'(m_pressed));
      check("key_code",    32'(key_code),    32'(m_code));
      check("key_multi",   32'(key_multi),   32'(m_multi));
      check("wait_valid",  32'(wait_valid),  32'(m_phase == 3));
      check("wait_code",   32'(wait_code),   32'(m_wcode));
      check("dbg_state",   32'(dbg_state),   32'(m_phase));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    wait_req = 1'b1; cycles(1); wait_req = 1'b0;
  endtask

  task automatic wait_for_valid(input int budget);
    int k = 0;
    while (wait_valid !== 1'b1 && k < budget) begin
      @(negedge clk); k++;
    end
    check("wait_valid_within_budget", 32'(wait_valid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; inputs = 16'hFFFF;
    cycles(3);
    check("rst_key_down",    32'(key_down),    32'd0);
    check("rst_key_pressed", 32'(key_pressed), 32'd0);
    check("rst_wait_valid",  32'(wait_valid),  32'd0);
    check("rst_state",       32'(dbg_state),   32'd0);
    rst = 1'b0; inputs = '0;
    cycles(LAT + 4);

`ifdef KEY_DEBOUNCE_EN
    inputs = 16'h0020; cycles(3);
    inputs = '0;       cycles(LAT + 3);
    check("glitch_rejected", 32'(key_down), 32'd0);
`endif

    inputs = 16'h0020;
    cycles(LAT - 1);
    check("kd_before_edge", 32'(key_down), 32'd0);
    cycles(1);
    check("kd_at_edge",       32'(key_down),    32'h0020);
    check("pressed_lags_kd",  32'(key_pressed), 32'd0);
    cycles(1);
    check("code_5",    32'(key_code),    32'd5);
    check("pressed_1", 32'(key_pressed), 32'd1);

    inputs = 16'h0208; cycles(LAT + 2);
    check("prio_code_3",  32'(key_code),  32'd3);
    check("prio_multi_1", 32'(key_multi), 32'd1);
    inputs = 16'h0200; cycles(LAT + 2);
    check("prio_code_9",  32'(key_code),  32'd9);
    check("prio_multi_0", 32'(key_multi), 32'd0);
    inputs = '0; cycles(LAT + 2);

    // Wait sequence with key 7 held before arming.
    inputs = 16'h0080; cycles(LAT + 2);
    pulse_req(); cycles(1);
    check("armed", 32'(dbg_state), 32'd1);
    inputs = 16'h1080; cycles(LAT + 2);
    check("hold",         32'(dbg_state),  32'd2);
    check("hold_novalid", 32'(wait_valid), 32'd0);
    inputs = 16'h1000; cycles(LAT + 2);
    check("key7_release_ignored", 32'(wait_valid), 32'd0);
    inputs = '0;
    wait_for_valid(LAT + 10);
    check("wait_code_12", 32'(wait_code), 32'd12);
    wait_ack = 1'b1; cycles(1); wait_ack = 1'b0;
    check("ack_drops_valid", 32'(wait_valid), 32'd0);
    check("ack_to_idle",     32'(dbg_state),  32'd0);

    // Ack and request together go straight back to ARMED.
    pulse_req();
    inputs = 16'h0002; cycles(LAT + 2);
    inputs = '0;
    wait_for_valid(LAT + 10);
    check("wait_code_1", 32'(wait_code), 32'd1);
    wait_ack = 1'b1; wait_req = 1'b1; cycles(1);
    wait_ack = 1'b0; wait_req = 1'b0;
    check("ackreq_valid_0", 32'(wait_valid), 32'd0);
    check("ackreq_armed",   32'(dbg_state),  32'd1);

    // Reset while holding a captured key.
    inputs = 16'h0004; cycles(LAT + 2);
    check("hold_key2", 32'(dbg_state), 32'd2);
    rst = 1'b1; cycles(2);
    rst = 1'b0; inputs = '0;
    for (int i = 0; i < LAT + 6; i++) begin
      cycles(1);
      check("no_valid_after_rst", 32'(wait_valid), 32'd0);
    end
    check("idle_after_rst", 32'(dbg_state), 32'd0);

    // Random traffic: sparse key vectors with random hold times, random handshakes.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) inputs = 16'($urandom()) & 16'($urandom()) & 16'($urandom());
      wait_req = ($urandom_range(0, 5) == 0);
      wait_ack = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 799) == 0);
      cycles(1);
    end
    rst = 1'b0; wait_req = 1'b0; wait_ack = 1'b0; inputs = '0;
    cycles(LAT + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
